fetch_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 27 ++
 rtl/fetch_unit_if.sv | 40 ++++
 rtl/fetch_out_reg.sv | 60 ++++++
 rtl/fetch_unit.sv | 98 +++++++++
 tb/tb_fetch_unit.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, instruction field positions and
// the fetch-stage state type.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd1;
    localparam logic [5:0] OP_SLL   = 6'd2;
    localparam logic [5:0] OP_SLT   = 6'd3;
    localparam logic [5:0] OP_SW    = 6'd4;
    localparam logic [5:0] OP_LW    = 6'd5;
    localparam logic [5:0] OP_BEQ   = 6'd6;
    localparam logic [5:0] OP_J     = 6'd7;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_e;

    function automatic logic is_jump(input logic [31:0] instr);
        return instr[OPC_MSB:OPC_LSB] == OP_J;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory port, execute redirect and decode handshake of the
// fetch stage. master = fetch side, slave = surrounding pipeline.
interface fetch_unit_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic              id_valid;
    logic              id_ready;
    logic [DATA_W-1:0] id_instr;
    logic [ADDR_W-1:0] id_pc;
    logic [ADDR_W-1:0] id_pc_next;

    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_addr,
        output id_valid,
        input  id_ready,
        output id_instr,
        output id_pc,
        output id_pc_next
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_addr,
        input  id_valid,
        output id_ready,
        input  id_instr,
        input  id_pc,
        input  id_pc_next
    );
endinterface

// File: rtl/fetch_out_reg.sv
// Valid/ready output register toward decode. Flush clears valid even while
// stalled; the data fields simply hold their last value.
module fetch_out_reg #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              load,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [ADDR_W-1:0] in_pc_next,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic [ADDR_W-1:0] out_pc_next
);
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_next_q, pc_next_d;

    always_comb begin
        valid_d   = valid_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        pc_next_d = pc_next_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d   = 1'b1;
            instr_d   = in_instr;
            pc_d      = in_pc;
            pc_next_d = in_pc_next;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            instr_q   <= '0;
            pc_q      <= '0;
            pc_next_q <= '0;
        end else begin
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            pc_next_q <= pc_next_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_instr   = instr_q;
    assign out_pc      = pc_q;
    assign out_pc_next = pc_next_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, predecodes jumps for zero-bubble redirection,
// honours execute redirects and feeds decode through fetch_out_reg.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W       = 6,
    parameter int                DATA_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter bit                STOP_ON_ZERO = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    fetch_unit_if.master        bus,
    output logic                done,
    output logic [15:0]         fetch_count
);
    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              done_q, done_d;
    logic [15:0]       fetch_count_q, fetch_count_d;

    logic              redirect;
    logic              load;
    logic              stop;
    logic              forward;
    logic [ADDR_W-1:0] pc_inc;

    assign bus.imem_addr = pc_q;
    assign pc_inc        = pc_q + PC_ONE;

    // Redirects only count once the program has been started.
    assign redirect = bus.redirect_valid && (state_q != IDLE);
    assign load     = (state_q == RUN) && !bus.redirect_valid
                      && (!bus.id_valid || bus.id_ready);
    assign stop     = load && STOP_ON_ZERO && (bus.imem_data == '0);
    assign forward  = load && !stop;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_count_d = fetch_count_q;
        if (state_q == IDLE) begin
            if (start) begin
                state_d = RUN;
            end
        end else if (redirect) begin
            // Also cancels a stop caused by a wrong-path zero word.
            pc_d    = bus.redirect_addr;
            state_d = RUN;
        end else if (stop) begin
            state_d = DONE;
        end else if (forward) begin
            pc_d = is_jump(bus.imem_data[31:0]) ? bus.imem_data[ADDR_W-1:0] : pc_inc;
            if (fetch_count_q != 16'hFFFF) begin
                fetch_count_d = fetch_count_q + 16'd1;
            end
        end
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            done_q        <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            done_q        <= done_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign done        = done_q;
    assign fetch_count = fetch_count_q;

    fetch_out_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (redirect),
        .load        (forward),
        .in_instr    (bus.imem_data),
        .in_pc       (pc_q),
        .in_pc_next  (pc_inc),
        .out_ready   (bus.id_ready),
        .out_valid   (bus.id_valid),
        .out_instr   (bus.id_instr),
        .out_pc      (bus.id_pc),
        .out_pc_next (bus.id_pc_next)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a program-level reference model checked every
// cycle, plus literal expectations taken from the hand-worked scenarios.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [5:0]  redirect_addr = '0;
    logic        id_ready = 1'b1;
    logic        done;
    logic [15:0] fetch_count;
    logic [31:0] mem [64];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(6), .DATA_W(32)) bus ();

    assign bus.imem_data      = mem[bus.imem_addr];
    assign bus.redirect_valid = redirect_valid;
    assign bus.redirect_addr  = redirect_addr;
    assign bus.id_ready       = id_ready;

    fetch_unit #(.ADDR_W(6), .DATA_W(32), .RESET_PC(6'd0), .STOP_ON_ZERO(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .bus         (bus.master),
        .done        (done),
        .fetch_count (fetch_count)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: program status (0 idle, 1 running, 2 stopped), the PC,
    // and the word currently offered to decode.
    int          m_state, m_pc, m_ipc, m_inext, m_cnt;
    logic [31:0] m_instr;
    bit          m_hv;
    bit          m_init = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        int          n_state, n_pc, n_ipc, n_inext, n_cnt;
        logic [31:0] n_instr, word;
        bit          n_hv, take;
        if (!rst_n) begin
            m_state <= 0; m_pc <= 0; m_ipc <= 0; m_inext <= 0; m_cnt <= 0;
            m_instr <= '0; m_hv <= 1'b0; m_init <= 1'b1;
        end else begin
            word = mem[m_pc];
            take = m_hv && id_ready;
            n_state = m_state; n_pc = m_pc; n_ipc = m_ipc; n_inext = m_inext;
            n_cnt = m_cnt; n_instr = m_instr; n_hv = m_hv;
            if (m_state == 0) begin
                if (start) n_state = 1;
                if (take) n_hv = 1'b0;
            end else if (redirect_valid) begin
                n_pc = int'(redirect_addr); n_hv = 1'b0; n_state = 1;
            end else if (m_state == 1 && (!m_hv || id_ready)) begin
                if (word == 32'h0) begin
                    n_state = 2; n_hv = 1'b0;
                end else begin
                    n_hv = 1'b1; n_instr = word; n_ipc = m_pc;
                    n_inext = (m_pc + 1) % 64;
                    n_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
                    n_pc = (word[31:26] == 6'd7) ? int'(word % 64) : (m_pc + 1) % 64;
                end
            end else if (take) begin
                n_hv = 1'b0;
            end
            m_state <= n_state; m_pc <= n_pc; m_ipc <= n_ipc; m_inext <= n_inext;
            m_cnt <= n_cnt; m_instr <= n_instr; m_hv <= n_hv;
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("imem_addr", bus.imem_addr, m_pc);
            chk("id_valid", bus.id_valid, m_hv);
            chk("id_instr", bus.id_instr, m_instr);
            chk("id_pc", bus.id_pc, m_ipc);
            chk("id_pc_next", bus.id_pc_next, m_inext);
            chk("done", done, (m_state == 2));
            chk("fetch_count", fetch_count, m_cnt);
            if (bus.id_valid && id_ready)
                $display("xfer t=%0t pc=%0d instr=%08h count=%0d", $time, bus.id_pc, bus.id_instr, fetch_count);
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0400_0000 | i;
        mem[0]  = 32'h1C00_0009;
        mem[41] = 32'h0;

        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        chk("rst_id_valid", bus.id_valid, 0);
        chk("rst_imem_addr", bus.imem_addr, 0);
        chk("rst_id_pc_next", bus.id_pc_next, 0);
        chk("rst_done", done, 0);
        chk("rst_fetch_count", fetch_count, 0);

        // Jump at 0 is predecoded: word 9 is addressed right after it.
        start = 1'b1; cyc();
        chk("start_addr", bus.imem_addr, 0);
        start = 1'b0; cyc();
        chk("jmp_instr", bus.id_instr, 32'h1C00_0009);
        chk("jmp_pc", bus.id_pc, 0);
        chk("jmp_next_addr", bus.imem_addr, 9);
        cyc();
        chk("w9_pc", bus.id_pc, 9);

        id_ready = 1'b0;
        repeat (3) begin
            cyc();
            chk("stall_pc", bus.id_pc, 9);
            chk("stall_addr", bus.imem_addr, 10);
        end
        id_ready = 1'b1;
        cyc(); chk("rel_pc10", bus.id_pc, 10);
        cyc(); chk("rel_pc11", bus.id_pc, 11);
        cyc(); chk("rel_pc12", bus.id_pc, 12);
        chk("count_after_12", fetch_count, 5);

        // Redirect while stalled discards the held word.
        id_ready = 1'b0; cyc();
        chk("held_valid", bus.id_valid, 1);
        redirect_valid = 1'b1; redirect_addr = 6'd22; cyc();
        chk("flush_valid", bus.id_valid, 0);
        chk("redir_addr", bus.imem_addr, 22);
        redirect_valid = 1'b0; id_ready = 1'b1; cyc();
        chk("redir_pc", bus.id_pc, 22);

        // Wrap-around at the top of the address space.
        redirect_valid = 1'b1; redirect_addr = 6'd63; cyc();
        chk("to63_addr", bus.imem_addr, 63);
        redirect_valid = 1'b0; cyc();
        chk("wrap_pc", bus.id_pc, 63);
        chk("wrap_pc_next", bus.id_pc_next, 0);
        chk("wrap_addr", bus.imem_addr, 0);

        // Word 0 is a jump, but the simultaneous redirect wins.
        redirect_valid = 1'b1; redirect_addr = 6'd41; cyc();
        chk("redir_over_jmp", bus.imem_addr, 41);
        redirect_valid = 1'b0; cyc();
        chk("zero_done", done, 1);
        chk("zero_not_fwd", bus.id_valid, 0);
        cyc();
        chk("zero_hold_addr", bus.imem_addr, 41);
        chk("zero_count", fetch_count, 7);
        redirect_valid = 1'b1; redirect_addr = 6'd15; cyc();
        chk("resume_done", done, 0);
        chk("resume_addr", bus.imem_addr, 15);
        redirect_valid = 1'b0; cyc();
        chk("resume_pc", bus.id_pc, 15);
        chk("resume_count", fetch_count, 8);

        // Asynchronous reset mid-run.
        cyc();
        rst_n = 1'b0; #1;
        chk("arst_valid", bus.id_valid, 0);
        chk("arst_addr", bus.imem_addr, 0);
        chk("arst_done", done, 0);
        chk("arst_count", fetch_count, 0);
        cyc();
        rst_n = 1'b1;
        repeat (3) begin
            cyc();
            chk("idle_addr", bus.imem_addr, 0);
            chk("idle_valid", bus.id_valid, 0);
        end
        start = 1'b1; cyc(); cyc();
        chk("restart_instr", bus.id_instr, 32'h1C00_0009);
        start = 1'b0;
        repeat (4) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
